// File: rtl/clasificador_vc.sv
// Ingress classifier: pops words from the main FIFO and steers each one to VC0 or VC1
// by its class bit, holding one word while the target VC is paused. Optional macro: CLASIFICADOR_CNT_EN.
module clasificador_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int CLASS_BIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] main_data,
  input  logic                  main_empty,
  input  logic                  VC0_pause,
  input  logic                  VC1_pause,
  output logic                  main_pop,
  output logic [DATA_WIDTH-1:0] VC0_data,
  output logic                  VC0_push,
  output logic [DATA_WIDTH-1:0] VC1_data,
  output logic                  VC1_push,
  output logic                  idle
`ifdef CLASIFICADOR_CNT_EN
  ,
  output logic [7:0]            cnt_vc0,
  output logic [7:0]            cnt_vc1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_STALL} state_t;

  state_t                state_q, state_d;
  logic                  in_flight_q, in_flight_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] vc0_data_q, vc0_data_d, vc1_data_q, vc1_data_d;
  logic                  vc0_push_q, vc0_push_d, vc1_push_q, vc1_push_d;

  logic                  cand_valid, dest, dest_pause, accept, block, stall;
  logic [DATA_WIDTH-1:0] cand;

  always_comb begin
    // The held word always goes first so global order is never broken.
    cand_valid = hold_valid_q | in_flight_q;
    cand       = hold_valid_q ? hold_q : main_data;
    dest       = cand[CLASS_BIT];
    dest_pause = dest ? VC1_pause : VC0_pause;
    accept     = cand_valid & ~dest_pause;
    block      = cand_valid & dest_pause;
    stall      = hold_valid_q | (in_flight_q & dest_pause);
    main_pop   = ~reset & ~main_empty & ~stall;

    in_flight_d  = main_pop;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept && hold_valid_q) hold_valid_d = 1'b0;
    if (block && !hold_valid_q) begin
      hold_d       = main_data;
      hold_valid_d = 1'b1;
    end

    vc0_push_d = accept & ~dest;
    vc1_push_d = accept & dest;
    vc0_data_d = vc0_push_d ? cand : vc0_data_q;
    vc1_data_d = vc1_push_d ? cand : vc1_data_q;

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (main_pop) state_d = S_ACTIVE;
      S_ACTIVE: if (block && !hold_valid_q)       state_d = S_STALL;
                else if (!in_flight_q && main_empty) state_d = S_IDLE;
      S_STALL:  if (accept) state_d = S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_flight_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      vc0_data_q   <= '0;
      vc1_data_q   <= '0;
      vc0_push_q   <= 1'b0;
      vc1_push_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_flight_q  <= in_flight_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      vc0_data_q   <= vc0_data_d;
      vc1_data_q   <= vc1_data_d;
      vc0_push_q   <= vc0_push_d;
      vc1_push_q   <= vc1_push_d;
    end
  end

  assign VC0_data = vc0_data_q;
  assign VC1_data = vc1_data_q;
  assign VC0_push = vc0_push_q;
  assign VC1_push = vc1_push_q;
  assign idle     = (state_q == S_IDLE) && main_empty;

`ifdef CLASIFICADOR_CNT_EN
  logic [7:0] cnt_vc0_q, cnt_vc0_d, cnt_vc1_q, cnt_vc1_d;

  // Counts advance on the same edge that registers the push; 8-bit wrap is intended.
  always_comb begin
    cnt_vc0_d = cnt_vc0_q + {7'd0, vc0_push_d};
    cnt_vc1_d = cnt_vc1_q + {7'd0, vc1_push_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_vc0_q <= 8'd0;
      cnt_vc1_q <= 8'd0;
    end else begin
      cnt_vc0_q <= cnt_vc0_d;
      cnt_vc1_q <= cnt_vc1_d;
    end
  end

  assign cnt_vc0 = cnt_vc0_q;
  assign cnt_vc1 = cnt_vc1_q;
`endif

endmodule

// File: tb/tb_clasificador_vc.sv
// Directed bench for clasificador_vc: main FIFO model, push log, per-scenario checks.
module tb_clasificador_vc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] main_data = 6'h00;
  logic       main_empty = 1'b1;
  logic       VC0_pause = 1'b0;
  logic       VC1_pause = 1'b0;
  logic       main_pop, VC0_push, VC1_push, idle;
  logic [5:0] VC0_data, VC1_data;
`ifdef CLASIFICADOR_CNT_EN
  logic [7:0] cnt_vc0, cnt_vc1;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit force_ne = 1'b0;

  typedef struct {
    bit         vc;
    logic [5:0] d;
    int         e;
  } push_t;

  logic [5:0] mq[$];
  push_t      outq[$];
  int         pop_e[$];
  push_t      p0, p1;

  clasificador_vc dut (
    .clk(clk), .reset(reset), .main_data(main_data), .main_empty(main_empty),
    .VC0_pause(VC0_pause), .VC1_pause(VC1_pause), .main_pop(main_pop),
    .VC0_data(VC0_data), .VC0_push(VC0_push), .VC1_data(VC1_data), .VC1_push(VC1_push),
    .idle(idle)
`ifdef CLASIFICADOR_CNT_EN
    , .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1)
`endif
  );

  always #5 clk = ~clk;

  // Main FIFO model: read data appears the cycle after the pop.
  always @(posedge clk) begin
    cyc++;
    if (main_pop) begin
      if (mq.size() > 0) main_data <= mq.pop_front();
      else               main_data <= 6'h00;
      pop_e.push_back(cyc);
    end
  end

  always begin
    @(posedge clk);
    #1;
    main_empty = !force_ne && (mq.size() == 0);
  end

  always @(negedge clk) begin
    if (VC0_push) begin
      p0.vc = 1'b0; p0.d = VC0_data; p0.e = cyc;
      outq.push_back(p0);
    end
    if (VC1_push) begin
      p1.vc = 1'b1; p1.d = VC1_data; p1.e = cyc;
      outq.push_back(p1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && outq.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_logs();
    outq.delete();
    pop_e.delete();
  endtask

  task automatic test_reset();
    force_ne = 1'b1; main_empty = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (main_pop !== 1'b0) begin fails++; $display("FAIL reset_pop got=%b exp=0", main_pop); end
    tests++; if (VC0_push !== 1'b0 || VC1_push !== 1'b0) begin fails++; $display("FAIL reset_push got=%b%b exp=00", VC0_push, VC1_push); end
    tests++; if (VC0_data !== 6'h00 || VC1_data !== 6'h00) begin fails++; $display("FAIL reset_data got=%h/%h exp=00/00", VC0_data, VC1_data); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got=%b exp=0", idle); end
    force_ne = 1'b0; main_empty = 1'b1; reset = 1'b0;
    @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle_after got=%b exp=1", idle); end
  endtask

  task automatic test_stream();
    logic [5:0] exp_d[4];
    bit         exp_vc[4];
    exp_d = '{6'h05, 6'h12, 6'h23, 6'h31};
    exp_vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_logs();
    for (int i = 0; i < 4; i++) mq.push_back(exp_d[i]);
    main_empty = 1'b0;
    wait_out(4, 30);
    repeat (3) @(negedge clk);
    tests++;
    if (outq.size() != 4 || pop_e.size() != 4) begin
      fails++; $display("FAIL stream_count got=%0d pushes/%0d pops exp=4/4", outq.size(), pop_e.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (outq[i].vc !== exp_vc[i] || outq[i].d !== exp_d[i]) begin
          fails++; $display("FAIL stream_word%0d got=vc%0d:%h exp=vc%0d:%h", i, outq[i].vc, outq[i].d, exp_vc[i], exp_d[i]);
        end
        tests++;
        if (outq[i].e != pop_e[i] + 1) begin
          fails++; $display("FAIL stream_latency%0d got=edge%0d exp=edge%0d", i, outq[i].e, pop_e[i] + 1);
        end
        tests++;
        if (outq[i].e != outq[0].e + i) begin
          fails++; $display("FAIL stream_rate%0d got=edge%0d exp=edge%0d", i, outq[i].e, outq[0].e + i);
        end
      end
    end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL stream_idle got=%b exp=1", idle); end
  endtask

  task automatic test_pause_block();
    clear_logs();
    VC1_pause = 1'b1;
    mq.push_back(6'h1A); mq.push_back(6'h03);
    main_empty = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (main_pop !== 1'b0) begin fails++; $display("FAIL pause_pop got=%b exp=0", main_pop); end
    tests++; if (outq.size() != 0) begin fails++; $display("FAIL pause_nopush got=%0d exp=0", outq.size()); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL pause_idle got=%b exp=0", idle); end
    VC1_pause = 1'b0;
    @(negedge clk);
    tests++; if (VC1_push !== 1'b1 || VC1_data !== 6'h1A || VC0_push !== 1'b0) begin
      fails++; $display("FAIL pause_release got=push%b%b data=%h exp=push01 data=1a", VC0_push, VC1_push, VC1_data);
    end
    tests++; if (main_pop !== 1'b1) begin fails++; $display("FAIL pause_resume got=%b exp=1", main_pop); end
    wait_out(2, 20);
    tests++;
    if (outq.size() != 2) begin fails++; $display("FAIL pause_after_count got=%0d exp=2", outq.size()); end
    else if (outq[1].vc !== 1'b0 || outq[1].d !== 6'h03) begin
      fails++; $display("FAIL pause_after_word got=vc%0d:%h exp=vc0:03", outq[1].vc, outq[1].d);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_order();
    clear_logs();
    VC1_pause = 1'b1;
    mq.push_back(6'h10); mq.push_back(6'h02);
    main_empty = 1'b0;
    repeat (6) @(negedge clk);
    tests++; if (outq.size() != 0) begin fails++; $display("FAIL order_bypass got=%0d pushes exp=0", outq.size()); end
    VC1_pause = 1'b0;
    wait_out(2, 20);
    tests++;
    if (outq.size() != 2) begin fails++; $display("FAIL order_count got=%0d exp=2", outq.size()); end
    else if (outq[0].vc !== 1'b1 || outq[0].d !== 6'h10 || outq[1].vc !== 1'b0 || outq[1].d !== 6'h02 || outq[1].e <= outq[0].e) begin
      fails++; $display("FAIL order_seq got=vc%0d:%h@%0d,vc%0d:%h@%0d exp=vc1:10 then vc0:02",
                        outq[0].vc, outq[0].d, outq[0].e, outq[1].vc, outq[1].d, outq[1].e);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_both_pause();
    clear_logs();
    VC0_pause = 1'b1; VC1_pause = 1'b1;
    mq.push_back(6'h07); mq.push_back(6'h15);
    main_empty = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (main_pop !== 1'b0 || outq.size() != 0) begin
      fails++; $display("FAIL both_pause got=pop%b pushes%0d exp=pop0 pushes0", main_pop, outq.size());
    end
    VC0_pause = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (outq.size() != 1) begin fails++; $display("FAIL both_vc0_only got=%0d pushes exp=1", outq.size()); end
    else if (outq[0].vc !== 1'b0 || outq[0].d !== 6'h07) begin
      fails++; $display("FAIL both_vc0_word got=vc%0d:%h exp=vc0:07", outq[0].vc, outq[0].d);
    end
    VC1_pause = 1'b0;
    wait_out(2, 20);
    tests++;
    if (outq.size() != 2) begin fails++; $display("FAIL both_vc1_count got=%0d exp=2", outq.size()); end
    else if (outq[1].vc !== 1'b1 || outq[1].d !== 6'h15) begin
      fails++; $display("FAIL both_vc1_word got=vc%0d:%h exp=vc1:15", outq[1].vc, outq[1].d);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    clear_logs();
    VC1_pause = 1'b1;
    mq.push_back(6'h3F);
    main_empty = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; VC1_pause = 1'b0;
    repeat (6) @(negedge clk);
    tests++; if (outq.size() != 0) begin fails++; $display("FAIL rst_stall_pushed got=%0d pushes exp=0", outq.size()); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_stall_idle got=%b exp=1", idle); end
  endtask

`ifdef CLASIFICADOR_CNT_EN
  task automatic test_counters();
    clear_logs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin fails++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", cnt_vc0, cnt_vc1); end
    for (int i = 0; i < 256; i++) mq.push_back(6'h01);
    for (int i = 0; i < 3; i++)   mq.push_back(6'h11);
    main_empty = 1'b0;
    wait_out(259, 400);
    repeat (3) @(negedge clk);
    tests++; if (cnt_vc0 !== 8'd0) begin fails++; $display("FAIL cnt_vc0_wrap got=%0d exp=0", cnt_vc0); end
    tests++; if (cnt_vc1 !== 8'd3) begin fails++; $display("FAIL cnt_vc1 got=%0d exp=3", cnt_vc1); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_pause_block();
    test_order();
    test_both_pause();
    test_reset_mid_stall();
`ifdef CLASIFICADOR_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clasificador_vc.md
Name: clasificador_vc

Overview:
- Ingress-side counterpart of the VC arbiter/router.
- Pops 6-bit words from the main ingress FIFO and classifies each word by one class bit.
- Pushes each word into the VC0 or VC1 FIFO, which the arbiter later drains.
- Honours each VC FIFO's almost-full pause flag, holding at most one word while the target VC is paused.

Parameters:
DATA_WIDTH, 6, width of main/VC words.
CLASS_BIT, 4, bit index selecting destination (0 -> VC0, 1 -> VC1).

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
main_data  input  DATA_WIDTH  main FIFO read data, valid the cycle after main_pop.
main_empty  input  1  main FIFO empty.
VC0_pause  input  1  VC0 FIFO almost-full.
VC1_pause  input  1  VC1 FIFO almost-full.
main_pop  output  1  read strobe to main FIFO (combinational).
VC0_data  output  DATA_WIDTH  write data to VC0 (registered).
VC0_push  output  1  write strobe to VC0 (registered).
VC1_data  output  DATA_WIDTH  write data to VC1 (registered).
VC1_push  output  1  write strobe to VC1 (registered).
idle  output  1  high when nothing is in flight or held, and main_empty=1.

Behaviour:
- Reset (reset=1 at an edge): VC0_data=VC1_data=0, VC0_push=VC1_push=0, in_flight=0, hold_valid=0, state=IDLE.
- main_pop is forced to 0 while reset=1.
- A reset asserted mid-operation discards any in-flight or held word; it is not pushed.
- in_flight register: set to 1 in the cycle after main_pop=1. While in_flight=1, main_data is the popped word.
- Candidate word: hold register if hold_valid=1, else main_data if in_flight=1.
- dest = candidate[CLASS_BIT]; dest_pause = VC0_pause if dest=0, else VC1_pause.
- Accept, when a candidate exists and dest_pause=0:
  - Next edge: VCdest_data <= candidate, VCdest_push <= 1.
  - The other VC's push <= 0.
  - hold_valid cleared if the candidate came from hold.
- Block, when a candidate exists and dest_pause=1:
  - If the candidate came from main_data, it is latched into hold (hold_valid <= 1).
  - Outputs push 0.
- Push strobes are 1 cycle wide per word. At most one push (VC0 or VC1) per cycle. VCx_data holds its last value when not pushing.
- Word order is preserved globally; no bypass of a held word.
- main_pop = !reset && !main_empty && !stall.
  - stall = hold_valid || (in_flight && dest_pause && !hold_valid).
  - A word already in flight always finds hold free, so the hold never overflows.
- Latency: pop at cycle N -> push registered at edge N+2 (visible in cycle N+2) when unpaused. Throughput is 1 word/cycle.
- FSM (state observable via idle and push behaviour):
  - IDLE: no in_flight, no hold. Go to ACTIVE when main_pop=1.
  - ACTIVE: streaming. Go to STALL when a word is latched into hold. Go to IDLE when in_flight=0 and main_empty=1.
  - STALL: hold_valid=1, main_pop=0. Go to ACTIVE when the held word is accepted.
- idle = (state==IDLE) && main_empty.
- Pause timing: pause is sampled in the same cycle as the candidate. A pause rising in that cycle blocks that word. VC FIFOs size their almost-full threshold for one extra registered push.
- Both pauses high: the word to either VC is held; popping stops.
- A word for an unpaused VC is never reordered ahead of a held word.

Optional Feature:
- Macro CLASIFICADOR_CNT_EN.
- When defined, adds output ports cnt_vc0 [7:0] and cnt_vc1 [7:0].
  - Each counts pushes into its VC.
  - Reset to 0; increment on the registered push.
  - Wrap 255 -> 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset with main_empty=0 -> main_pop=0, both pushes 0, data outputs 0x00, idle=0. After release with main_empty=1 -> idle=1.
- Stream with no pause: words 0x05, 0x12, 0x23, 0x31 popped back-to-back -> VC0 receives 0x05, 0x23; VC1 receives 0x12, 0x31. Each push occurs 2 cycles after its pop; one push per cycle.
- Pause block: VC1_pause=1 while word 0x1A arrives -> hold_valid=1, main_pop=0, no pushes. Release VC1_pause -> next edge VC1_push=1 with VC1_data=0x1A, then popping resumes.
- Order preservation: held 0x10 (VC1 paused) followed by queued 0x02 (VC0) -> 0x02 is not pushed until 0x10 has been pushed.
- Reset mid-stall: hold 0x3F, then assert reset for 1 cycle -> 0x3F is never pushed; state=IDLE.
- With CLASIFICADOR_CNT_EN: 256 words to VC0 and 3 to VC1 -> cnt_vc0=0 (wrapped), cnt_vc1=3.
